// File: rtl/gate_pkg.sv
// ---------------------------------------------------------------------------
// gate_pkg
// Shared definitions for the two-input gate library test logic:
//   - 3-bit classification codes GATE_UNKNOWN .. GATE_NOT_A
//   - 4-bit truth patterns TT_OR .. TT_NOT_A, indexed as truth[{a,b}]
//   - state encoding of the gate_prober FSM
// ---------------------------------------------------------------------------
package gate_pkg;

  localparam logic [2:0] GATE_UNKNOWN = 3'd0;
  localparam logic [2:0] GATE_OR      = 3'd1;
  localparam logic [2:0] GATE_NOR     = 3'd2;
  localparam logic [2:0] GATE_AND     = 3'd3;
  localparam logic [2:0] GATE_NAND    = 3'd4;
  localparam logic [2:0] GATE_XOR     = 3'd5;
  localparam logic [2:0] GATE_XNOR    = 3'd6;
  localparam logic [2:0] GATE_NOT_A   = 3'd7;

  // Bit n holds the gate output for input vector n = {a,b}.
  localparam logic [3:0] TT_OR    = 4'b1110;
  localparam logic [3:0] TT_NOR   = 4'b0001;
  localparam logic [3:0] TT_AND   = 4'b1000;
  localparam logic [3:0] TT_NAND  = 4'b0111;
  localparam logic [3:0] TT_XOR   = 4'b0110;
  localparam logic [3:0] TT_XNOR  = 4'b1001;
  localparam logic [3:0] TT_NOT_A = 4'b0011;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_REPORT = 2'd3
  } prober_state_t;

endpackage

// File: rtl/gate_classify.sv
// ---------------------------------------------------------------------------
// gate_classify
// Purely combinational classifier: maps a 4-bit truth table to the library
// gate code. An unreliable table (x_flag set) always classifies as UNKNOWN.
// Ports:
//   i_truth     [3:0] truth table, bit {a,b} = gate output
//   i_x_flag          a non-0/1 value was sampled while building i_truth
//   o_gate_code [2:0] classification code
// ---------------------------------------------------------------------------
module gate_classify
  import gate_pkg::*;
(
  input  logic [3:0] i_truth,
  input  logic       i_x_flag,
  output logic [2:0] o_gate_code
);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path through the block leaves it unassigned and infers a latch.
    o_gate_code = GATE_UNKNOWN;
    if (!i_x_flag) begin
      case (i_truth)
        TT_OR:    o_gate_code = GATE_OR;
        TT_NOR:   o_gate_code = GATE_NOR;
        TT_AND:   o_gate_code = GATE_AND;
        TT_NAND:  o_gate_code = GATE_NAND;
        TT_XOR:   o_gate_code = GATE_XOR;
        TT_XNOR:  o_gate_code = GATE_XNOR;
        TT_NOT_A: o_gate_code = GATE_NOT_A;
        default:  o_gate_code = GATE_UNKNOWN;
      endcase
    end
  end

endmodule

// File: rtl/gate_prober.sv
// ---------------------------------------------------------------------------
// gate_prober
// Sequential truth-table prober. On start it drives the vectors 00,01,10,11
// ({a,b}) onto an external gate, holds each for SETTLE_CYCLES cycles, samples
// the gate output in a following one-cycle SAMPLE state, then reports the
// 4-bit truth table and its classification.
// Ports:
//   clk, rst        clock (rising edge), synchronous active-high reset
//   start           begin a probe run (taken only when no run is active)
//   a_out, b_out    drive gate inputs a and b
//   y_in            gate under test output
//   busy            high from the start-accept edge until REPORT is entered
//   done            one-cycle pulse while in REPORT
//   truth [3:0]     truth[{a,b}] = sampled y, held between runs
//   gate_code [2:0] classification, held between runs
// ---------------------------------------------------------------------------
module gate_prober
  import gate_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       a_out,
  output logic       b_out,
  input  logic       y_in,
  output logic       busy,
  output logic       done,
  output logic [3:0] truth,
  output logic [2:0] gate_code
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  prober_state_t    r_state,  w_state_nxt;
  logic [1:0]       r_idx,    w_idx_nxt;
  logic [CNT_W-1:0] r_cnt,    w_cnt_nxt;
  logic [1:0]       r_ab,     w_ab_nxt;
  logic [3:0]       r_shadow, w_shadow_nxt;
  logic             r_x_flag, w_x_flag_nxt;
  logic             r_busy,   w_busy_nxt;
  logic             r_done,   w_done_nxt;
  logic [3:0]       r_truth,  w_truth_nxt;
  logic [2:0]       r_code,   w_code_nxt;

  logic [3:0]       w_table_cap;
  logic             w_x_cap;
  logic             w_y_is_x;
  logic [2:0]       w_code_cls;

  // Case-inequality catches X/Z on y_in in simulation; in hardware it is
  // constant false.
  assign w_y_is_x = (y_in !== 1'b0) && (y_in !== 1'b1);

  // Table and flag as they stand once the current sample is folded in. The
  // last sample and the report land on the same edge, so REPORT publishes
  // these rather than waiting a cycle for the shadow register.
  always_comb begin
    w_table_cap        = r_shadow;
    w_table_cap[r_idx] = y_in;
  end
  assign w_x_cap = r_x_flag | w_y_is_x;

  gate_classify u_classify (
    .i_truth     (w_table_cap),
    .i_x_flag    (w_x_cap),
    .o_gate_code (w_code_cls)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_cnt_nxt    = r_cnt;
    w_ab_nxt     = r_ab;
    w_shadow_nxt = r_shadow;
    w_x_flag_nxt = r_x_flag;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 1'b0;
    w_truth_nxt  = r_truth;
    w_code_nxt   = r_code;

    case (r_state)
      // REPORT's closing edge may already accept the next start, giving a
      // held start one run every 4*(SETTLE_CYCLES+1)+1 cycles.
      ST_IDLE, ST_REPORT: begin
        w_state_nxt = ST_IDLE;
        if (start) begin
          w_state_nxt  = ST_SETTLE;
          w_idx_nxt    = 2'd0;
          w_cnt_nxt    = '0;
          w_ab_nxt     = 2'b00;
          w_shadow_nxt = 4'b0000;
          w_x_flag_nxt = 1'b0;
          w_busy_nxt   = 1'b1;
        end
      end

      ST_SETTLE: begin
        if (r_cnt == CNT_LAST) begin
          w_state_nxt = ST_SAMPLE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      ST_SAMPLE: begin
        w_shadow_nxt = w_table_cap;
        w_x_flag_nxt = w_x_cap;
        if (r_idx != 2'd3) begin
          w_idx_nxt   = r_idx + 2'd1;
          w_ab_nxt    = r_idx + 2'd1;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_SETTLE;
        end else begin
          w_state_nxt = ST_REPORT;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
          w_truth_nxt = w_table_cap;
          w_code_nxt  = w_code_cls;
        end
      end

      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_idx    <= 2'd0;
      r_cnt    <= '0;
      r_ab     <= 2'b00;
      r_shadow <= 4'b0000;
      r_x_flag <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_truth  <= 4'b0000;
      r_code   <= GATE_UNKNOWN;
    end else begin
      r_state  <= w_state_nxt;
      r_idx    <= w_idx_nxt;
      r_cnt    <= w_cnt_nxt;
      r_ab     <= w_ab_nxt;
      r_shadow <= w_shadow_nxt;
      r_x_flag <= w_x_flag_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_truth  <= w_truth_nxt;
      r_code   <= w_code_nxt;
    end
  end

  assign a_out     = r_ab[1];
  assign b_out     = r_ab[0];
  assign busy      = r_busy;
  assign done      = r_done;
  assign truth     = r_truth;
  assign gate_code = r_code;

endmodule
